// File: rtl/coproc_scheduler_pkg.sv
// Shared definitions for the coprocessor scheduler: unit FSM encoding and
// default opcodes and clock-gate delay, also used by the decoder.
package coproc_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWake = 3'd1,
    StReq  = 3'd2,
    StWait = 3'd3,
    StDone = 3'd4
  } unit_state_e;

  localparam logic [3:0]  FPU_OP_DEF   = 4'b0110;
  localparam logic [3:0]  CRY_OP_DEF   = 4'b0111;
  localparam int unsigned GATE_DLY_DEF = 8;

endpackage

// File: rtl/coproc_unit_ctrl.sv
// Per-unit controller: request/response FSM, operand and result latches,
// and the idle counter that drives the registered clock enable.
module coproc_unit_ctrl
  import coproc_scheduler_pkg::*;
#(
  parameter int unsigned GATE_DLY = GATE_DLY_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_accept,
  input  logic [2:0]  i_func,
  input  logic [3:0]  i_rd,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_req_ready,
  input  logic        i_rsp_valid,
  input  logic [31:0] i_rsp_data,
  input  logic        i_grant,
  output logic        o_idle,
  output logic        o_done,
  output logic        o_req_valid,
  output logic [2:0]  o_func,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [3:0]  o_rd,
  output logic [31:0] o_data,
  output logic        o_clk_en
);

  localparam int unsigned  CntW    = $clog2(GATE_DLY + 1);
  localparam logic [CntW-1:0] GateMax = CntW'(GATE_DLY);

  unit_state_e     r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_clk_en, w_clk_en_d;
  logic [2:0]      r_func;
  logic [3:0]      r_rd;
  logic [31:0]     r_a, r_b, r_data;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (i_accept) w_state_d = r_clk_en ? StReq : StWake;
      StWake:  w_state_d = StReq;
      StReq:   if (i_req_ready) w_state_d = StWait;
      // Response in the handshake cycle is ignored: only WAIT samples it.
      StWait:  if (i_rsp_valid) w_state_d = StDone;
      StDone:  if (i_grant) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_accept) begin
      w_cnt_d = '0;
    end else if (r_state == StIdle && r_cnt != GateMax) begin
      w_cnt_d = r_cnt + 1'b1;
    end
    w_clk_en_d = (w_state_d != StIdle) || (r_clk_en && w_cnt_d != GateMax);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_clk_en <= 1'b0;
      r_func   <= '0;
      r_rd     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_data   <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_clk_en <= w_clk_en_d;
      if (i_accept) begin
        r_func <= i_func;
        r_rd   <= i_rd;
        r_a    <= i_a;
        r_b    <= i_b;
      end
      if (r_state == StWait && i_rsp_valid) r_data <= i_rsp_data;
    end
  end

  assign o_idle      = (r_state == StIdle);
  assign o_done      = (r_state == StDone);
  assign o_req_valid = (r_state == StReq);
  assign o_func      = r_func;
  assign o_a         = r_a;
  assign o_b         = r_b;
  assign o_rd        = r_rd;
  assign o_data      = r_data;
  assign o_clk_en    = r_clk_en;

endmodule

// File: rtl/coproc_scheduler.sv
// Dispatches decoded FPU/crypto ops to two unit controllers, stalls decode on
// busy or rd conflicts, and round-robin arbitrates the single writeback port.
module coproc_scheduler
  import coproc_scheduler_pkg::*;
#(
  parameter logic [3:0]  FPU_OP   = FPU_OP_DEF,
  parameter logic [3:0]  CRY_OP   = CRY_OP_DEF,
  parameter int unsigned GATE_DLY = GATE_DLY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [3:0]  issue_op,
  input  logic [2:0]  issue_func,
  input  logic [3:0]  issue_rd,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  output logic        stall,
  output logic        fpu_req_valid,
  input  logic        fpu_req_ready,
  output logic [2:0]  fpu_func,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic        fpu_rsp_valid,
  input  logic [31:0] fpu_rsp_data,
  output logic        fpu_clk_en,
  output logic        cry_req_valid,
  input  logic        cry_req_ready,
  output logic [2:0]  cry_func,
  output logic [31:0] cry_a,
  output logic [31:0] cry_b,
  input  logic        cry_rsp_valid,
  input  logic [31:0] cry_rsp_data,
  output logic        cry_clk_en,
  output logic        wb_valid,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data
);

  logic        w_fpu_idle, w_fpu_done, w_cry_idle, w_cry_done;
  logic [3:0]  w_fpu_rd, w_cry_rd;
  logic [31:0] w_fpu_data, w_cry_data;
  logic        w_fpu_hit, w_cry_hit, w_fpu_ok, w_cry_ok;
  logic        w_fpu_acc, w_cry_acc, w_gnt_fpu, w_gnt_cry;
  logic        r_last_cry;

  // A unit is free only if idle and the other busy unit does not own issue_rd.
  always_comb begin
    w_fpu_hit = issue_valid && (issue_op == FPU_OP);
    w_cry_hit = issue_valid && (issue_op == CRY_OP);
    w_fpu_ok  = w_fpu_hit && w_fpu_idle && (w_cry_idle || issue_rd != w_cry_rd);
    w_cry_ok  = w_cry_hit && w_cry_idle && (w_fpu_idle || issue_rd != w_fpu_rd);
    w_fpu_acc = w_fpu_ok && !rst;
    w_cry_acc = w_cry_ok && !rst;
    stall     = !rst && ((w_fpu_hit && !w_fpu_ok) || (w_cry_hit && !w_cry_ok));
  end

  always_comb begin
    w_gnt_fpu = w_fpu_done && (!w_cry_done || r_last_cry);
    w_gnt_cry = w_cry_done && !w_gnt_fpu;
    wb_valid  = w_gnt_fpu || w_gnt_cry;
    wb_rd     = '0;
    wb_data   = '0;
    if (w_gnt_fpu) begin
      wb_rd   = w_fpu_rd;
      wb_data = w_fpu_data;
    end else if (w_gnt_cry) begin
      wb_rd   = w_cry_rd;
      wb_data = w_cry_data;
    end
  end

  // Priority only rotates on contention; a lone grant leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_cry <= 1'b1;
    end else if (w_fpu_done && w_cry_done) begin
      r_last_cry <= w_gnt_cry;
    end
  end

  coproc_unit_ctrl #(
    .GATE_DLY (GATE_DLY)
  ) u_fpu (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_accept    (w_fpu_acc),
    .i_func      (issue_func),
    .i_rd        (issue_rd),
    .i_a         (issue_a),
    .i_b         (issue_b),
    .i_req_ready (fpu_req_ready),
    .i_rsp_valid (fpu_rsp_valid),
    .i_rsp_data  (fpu_rsp_data),
    .i_grant     (w_gnt_fpu),
    .o_idle      (w_fpu_idle),
    .o_done      (w_fpu_done),
    .o_req_valid (fpu_req_valid),
    .o_func      (fpu_func),
    .o_a         (fpu_a),
    .o_b         (fpu_b),
    .o_rd        (w_fpu_rd),
    .o_data      (w_fpu_data),
    .o_clk_en    (fpu_clk_en)
  );

  coproc_unit_ctrl #(
    .GATE_DLY (GATE_DLY)
  ) u_cry (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_accept    (w_cry_acc),
    .i_func      (issue_func),
    .i_rd        (issue_rd),
    .i_a         (issue_a),
    .i_b         (issue_b),
    .i_req_ready (cry_req_ready),
    .i_rsp_valid (cry_rsp_valid),
    .i_rsp_data  (cry_rsp_data),
    .i_grant     (w_gnt_cry),
    .o_idle      (w_cry_idle),
    .o_done      (w_cry_done),
    .o_req_valid (cry_req_valid),
    .o_func      (cry_func),
    .o_a         (cry_a),
    .o_b         (cry_b),
    .o_rd        (w_cry_rd),
    .o_data      (w_cry_data),
    .o_clk_en    (cry_clk_en)
  );

endmodule

// File: doc/coproc_scheduler.md
COPROC_SCHEDULER -- requirements
Module: coproc_scheduler

Interface
REQ-001 Parameters SHALL be: FPU_OP, default 4'b0110, FPU opcode; CRY_OP, default 4'b0111, crypto opcode; GATE_DLY, default 8, idle cycles before clock-enable drop.
REQ-002 Ports SHALL be as follows: clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 issue_valid  in  1  decode stage presents an instruction; issue_op  in  4  opcode; issue_func  in  3  unit sub-op; issue_rd  in  4  dest reg; issue_a, issue_b  in  32  operands.
REQ-005 stall  out  1  combinational; holds decode stage this cycle.
REQ-006 fpu_req_valid  out  1; fpu_req_ready  in  1; fpu_func  out  3; fpu_a, fpu_b  out  32; fpu_rsp_valid  in  1; fpu_rsp_data  in  32; fpu_clk_en  out  1.
REQ-007 cry_* ports SHALL mirror REQ-006 exactly for the crypto core.
REQ-008 wb_valid  out  1  one-cycle writeback pulse; wb_rd  out  4; wb_data  out  32.

Function
REQ-009 Each unit SHALL have an independent FSM: IDLE, WAKE, REQ, WAIT, DONE; both units may be busy concurrently, one op outstanding per unit.
REQ-010 An issue SHALL be accepted when issue_valid=1, issue_op matches the unit's opcode, the unit is IDLE, and issue_rd differs from the rd held by the other unit when that unit is not IDLE.
REQ-011 stall SHALL be 1 when issue_valid=1, issue_op matches FPU_OP or CRY_OP, and REQ-010 is not met; stall SHALL be 0 for all other opcodes.
REQ-012 On acceptance the unit SHALL latch func, rd, a, b and go to REQ if its clk_en is already 1, else to WAKE.
REQ-013 WAKE SHALL last exactly one cycle, during which clk_en is 1 and req_valid is 0, then go to REQ.
REQ-014 In REQ, req_valid=1 with latched func/a/b held stable; on req_ready=1 the unit SHALL go to WAIT.
REQ-015 In WAIT, on rsp_valid=1 the unit SHALL latch rsp_data and go to DONE; rsp_valid SHALL be ignored in all other states.
REQ-016 Units SHALL assert rsp_valid no earlier than one cycle after the req handshake; same-cycle ready+rsp SHALL be treated as ready only.
REQ-017 Writeback arbitration: exactly one DONE unit SHALL be granted per cycle; if both are DONE, round-robin via a last-grant bit (reset value: crypto last, so FPU wins first).
REQ-018 The granted unit SHALL drive wb_valid=1, wb_rd, wb_data that cycle and return to IDLE next cycle; the loser SHALL stay in DONE.
REQ-019 A unit returning to IDLE SHALL NOT accept an issue in the same cycle as its grant (stall=1 that cycle).
REQ-020 clk_en SHALL be registered: 1 in any non-IDLE state; in IDLE a per-unit counter SHALL count up to GATE_DLY, saturating, and clk_en SHALL drop to 0 when the count reaches GATE_DLY; the counter SHALL clear on acceptance.
REQ-021 wb_rd and wb_data SHALL be 0 when wb_valid=0.

Reset
REQ-022 On rst, all FSMs SHALL go to IDLE and all req_valid, wb_valid, wb_rd, wb_data, clk_en, counters and latched fields SHALL go to 0; the last-grant bit SHALL take its reset value.
REQ-023 Reset mid-operation SHALL abandon in-flight ops; a late rsp_valid after reset SHALL produce no writeback.
REQ-024 stall SHALL be 0 during reset regardless of inputs.

Structure
REQ-025 FSM state encodings, FPU_OP/CRY_OP defaults and GATE_DLY default SHALL live in a shared package used by the decoder and this block.
REQ-026 One sub-module, coproc_unit_ctrl, SHALL implement the per-unit FSM, operand latch and gate counter, instantiated twice; arbitration and stall logic SHALL stay in the top module.

Verification
REQ-027 Issue FPU op (rd=3, a=5, b=7) from reset: WAKE 1 cycle, req 1 cycle with ready=1, rsp=0x0C two cycles later -> wb_valid=1, wb_rd=3, wb_data=0x0C for one cycle.
REQ-028 FPU busy in WAIT, second FPU issue -> stall=1 until the cycle after writeback; crypto issue in the same window is accepted with stall=0.
REQ-029 Both units reach DONE in the same cycle -> FPU written back first, crypto next cycle; repeat the test -> crypto is granted first.
REQ-030 Crypto holds rd=5, FPU issue with rd=5 -> stall=1 until crypto writeback completes.
REQ-031 10 idle cycles after writeback -> clk_en drops after exactly 8 cycles; a new issue then takes the WAKE path and an issue before the 8th cycle skips it.
REQ-032 Assert rst while FPU is in WAIT, then pulse fpu_rsp_valid -> no wb_valid, all outputs 0.
